alu_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the ALU/register-file/bit-RAM/word-RAM datapath. It fetches instruction words from a synchronous instruction ROM and decodes them. It drives the datapath's op_code, source/destination addresses and choices, and push/pop, and resolves jumps on the datapath zero_flag. It owns the program counter and a small hardware return-address stack, and sits directly above the datapath.

---
 rtl/alu_seq_pkg.sv | 62 ++++++
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_seq_stack.sv | 52 +++++
 rtl/alu_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and instruction field layout for the ALU sequencer.
// ALU_SEQ_SINGLE_STEP_EN adds the STEPWAIT state.
package alu_seq_pkg;

   localparam int INSTR_WIDTH = 43;

   localparam int CTL_MSB  = 42;
   localparam int CTL_LSB  = 40;
   localparam int OP_MSB   = 39;
   localparam int OP_LSB   = 32;
   localparam int S1C_MSB  = 31;
   localparam int S1C_LSB  = 30;
   localparam int S2C_MSB  = 29;
   localparam int S2C_LSB  = 28;
   localparam int DC_MSB   = 27;
   localparam int DC_LSB   = 26;
   localparam int RSVD_MSB = 25;
   localparam int RSVD_LSB = 24;
   localparam int SRC1_MSB = 23;
   localparam int SRC1_LSB = 16;
   localparam int SRC2_MSB = 15;
   localparam int SRC2_LSB = 8;
   localparam int DEST_MSB = 7;
   localparam int DEST_LSB = 0;

   localparam logic [1:0] DEST_NONE = 2'b11;

   typedef enum logic [2:0] {
      CTL_ALU  = 3'b000,
      CTL_JMP  = 3'b001,
      CTL_JZ   = 3'b010,
      CTL_JNZ  = 3'b011,
      CTL_CALL = 3'b100,
      CTL_RET  = 3'b101,
      CTL_HALT = 3'b110,
      CTL_NOP  = 3'b111
   } ctl_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_HALT
`ifdef ALU_SEQ_SINGLE_STEP_EN
      , ST_STEPWAIT
`endif
   } state_e;

   // Decoded instruction register; the reserved bits are dropped at capture.
   typedef struct packed {
      ctl_e       ctl;
      logic [7:0] op;
      logic [1:0] s1c;
      logic [1:0] s2c;
      logic [1:0] dc;
      logic [7:0] src1;
      logic [7:0] src2;
      logic [7:0] dest;
   } instr_t;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction-ROM and datapath bus between the sequencer (master) and the
// datapath/ROM side (slave).
interface alu_seq_if #(
   parameter int PC_WIDTH   = 6,
   parameter int IWIDTH     = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int SOURCES    = 4
);
   import alu_seq_pkg::*;

   localparam int CW = $clog2(SOURCES);

   logic [PC_WIDTH-1:0]    imem_addr;
   logic [INSTR_WIDTH-1:0] imem_data;
   logic [IWIDTH-1:0]      op_code;
   logic [IWIDTH-1:0]      source1;
   logic [IWIDTH-1:0]      source2;
   logic [CW-1:0]          source1_choice;
   logic [CW-1:0]          source2_choice;
   logic [ADDR_WIDTH-1:0]  destination;
   logic [1:0]             dest_choice;
   logic                   push;
   logic                   pop;
   logic [PC_WIDTH-1:0]    instr_addr;
   logic                   zero_flag;

   modport master (
      output imem_addr, op_code, source1, source2, source1_choice,
             source2_choice, destination, dest_choice, push, pop, instr_addr,
      input  imem_data, zero_flag
   );

   modport slave (
      input  imem_addr, op_code, source1, source2, source1_choice,
             source2_choice, destination, dest_choice, push, pop, instr_addr,
      output imem_data, zero_flag
   );

endinterface

// File: rtl/alu_seq_stack.sv
// Return-address LIFO for CALL/RET. Push and pop are never requested together;
// push when full and pop when empty are ignored.
module alu_seq_stack #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] ONE = (PW+1)'(1);
   localparam logic [PW:0] CAP = (PW+1)'(DEPTH);

   logic [PW:0]      count;
   logic [PW-1:0]    wr_idx;
   logic [PW-1:0]    top_idx;
   logic [WIDTH-1:0] mem [DEPTH];

   assign full    = (count == CAP);
   assign empty   = (count == '0);
   assign wr_idx  = count[PW-1:0];
   assign top_idx = count[PW-1:0] - PW'(1);
   assign dout    = mem[top_idx];

   // Occupancy counter; clr wins so a restart always begins with an empty stack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + ONE;
      end else if (pop && !empty) begin
         count <= count - ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !clr) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer driving the ALU datapath.
// ALU_SEQ_SINGLE_STEP_EN adds the step input and a STEPWAIT state after EXEC.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int PC_WIDTH    = 6,
   parameter int IWIDTH      = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int SOURCES     = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     start,
`ifdef ALU_SEQ_SINGLE_STEP_EN
   input  logic     step,
`endif
   alu_seq_if.master bus,
   output logic     busy,
   output logic     halted,
   output logic     fault
);

   localparam int CW = $clog2(SOURCES);

   state_e              state;
   state_e              state_nxt;
   state_e              after_exec;
   instr_t              ir;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_nxt;
   logic [PC_WIDTH-1:0] pc_inc;
   logic [PC_WIDTH-1:0] target;
   logic                restart;
   logic                fault_set;
   logic                stk_push;
   logic                stk_pop;
   logic                stk_full;
   logic                stk_empty;
   logic [PC_WIDTH-1:0] stk_dout;
   logic [1:0]          rsvd_unused;

   assign rsvd_unused = bus.imem_data[RSVD_MSB:RSVD_LSB];
   assign pc_inc      = pc + PC_WIDTH'(1);
   assign target      = ir.dest[PC_WIDTH-1:0];
   assign restart     = start && (state == ST_IDLE || state == ST_HALT);

`ifdef ALU_SEQ_SINGLE_STEP_EN
   assign after_exec = ST_STEPWAIT;
`else
   assign after_exec = ST_FETCH;
`endif

   alu_seq_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (PC_WIDTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (stk_push),
      .pop   (stk_pop),
      .clr   (restart),
      .din   (pc_inc),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty)
   );

   // State register, program counter, instruction register and sticky fault.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         pc    <= '0;
         ir    <= '{ctl: CTL_NOP, default: '0};
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         if (restart) begin
            pc    <= '0;
            fault <= 1'b0;
         end else begin
            pc <= pc_nxt;
            if (fault_set) begin
               fault <= 1'b1;
            end
         end
         if (state == ST_DECODE) begin
            ir <= '{ctl:  ctl_e'(bus.imem_data[CTL_MSB:CTL_LSB]),
                    op:   bus.imem_data[OP_MSB:OP_LSB],
                    s1c:  bus.imem_data[S1C_MSB:S1C_LSB],
                    s2c:  bus.imem_data[S2C_MSB:S2C_LSB],
                    dc:   bus.imem_data[DC_MSB:DC_LSB],
                    src1: bus.imem_data[SRC1_MSB:SRC1_LSB],
                    src2: bus.imem_data[SRC2_MSB:SRC2_LSB],
                    dest: bus.imem_data[DEST_MSB:DEST_LSB]};
         end
      end
   end

   // Next state and next pc; stack overflow/underflow aborts into HALT.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      fault_set = 1'b0;
      unique case (state)
         ST_IDLE, ST_HALT: begin
            if (start) state_nxt = ST_FETCH;
         end
         ST_FETCH:  state_nxt = ST_DECODE;
         ST_DECODE: state_nxt = ST_EXEC;
         ST_EXEC: begin
            state_nxt = after_exec;
            unique case (ir.ctl)
               CTL_ALU, CTL_NOP: pc_nxt = pc_inc;
               CTL_JMP:          pc_nxt = target;
               CTL_JZ:           pc_nxt = bus.zero_flag ? target : pc_inc;
               CTL_JNZ:          pc_nxt = bus.zero_flag ? pc_inc : target;
               CTL_CALL: begin
                  if (stk_full) begin
                     fault_set = 1'b1;
                     state_nxt = ST_HALT;
                  end else begin
                     stk_push = 1'b1;
                     pc_nxt   = target;
                  end
               end
               CTL_RET: begin
                  if (stk_empty) begin
                     fault_set = 1'b1;
                     state_nxt = ST_HALT;
                  end else begin
                     stk_pop = 1'b1;
                     pc_nxt  = stk_dout;
                  end
               end
               CTL_HALT: state_nxt = ST_HALT;
            endcase
         end
`ifdef ALU_SEQ_SINGLE_STEP_EN
         ST_STEPWAIT: begin
            if (step) state_nxt = ST_FETCH;
         end
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign bus.imem_addr      = pc;
   assign bus.op_code        = IWIDTH'(ir.op);
   assign bus.source1        = IWIDTH'(ir.src1);
   assign bus.source2        = IWIDTH'(ir.src2);
   assign bus.source1_choice = CW'(ir.s1c);
   assign bus.source2_choice = CW'(ir.s2c);
   assign bus.destination    = ADDR_WIDTH'(ir.dest);
   assign bus.dest_choice    = (state == ST_EXEC && ir.ctl == CTL_ALU) ? ir.dc : DEST_NONE;
   assign bus.push           = stk_push;
   assign bus.pop            = stk_pop;
   assign bus.instr_addr     = stk_push ? pc_inc : pc;

   assign halted = (state == ST_HALT);
`ifdef ALU_SEQ_SINGLE_STEP_EN
   assign busy = (state == ST_FETCH) || (state == ST_DECODE) ||
                 (state == ST_EXEC)  || (state == ST_STEPWAIT);
`else
   assign busy = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXEC);
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a bench-side synchronous ROM.
// Builds with or without ALU_SEQ_SINGLE_STEP_EN.
module tb_alu_seq_ctrl;

   localparam logic [2:0] C_ALU = 3'b000, C_JMP = 3'b001, C_JZ = 3'b010, C_JNZ = 3'b011;
   localparam logic [2:0] C_CALL = 3'b100, C_RET = 3'b101, C_HALT = 3'b110, C_NOP = 3'b111;
`ifdef ALU_SEQ_SINGLE_STEP_EN
   localparam int HALT_CYC = 8;
`else
   localparam int HALT_CYC = 7;
`endif

   logic clk;
   logic rst;
   logic start;
   logic busy;
   logic halted;
   logic fault;
`ifdef ALU_SEQ_SINGLE_STEP_EN
   logic step;
`endif
   logic [42:0] rom [64];
   int checks;
   int errors;

   alu_seq_if #(.PC_WIDTH(6), .IWIDTH(8), .ADDR_WIDTH(8), .SOURCES(4)) bus ();

   alu_seq_ctrl #(
      .PC_WIDTH(6), .IWIDTH(8), .ADDR_WIDTH(8), .SOURCES(4), .STACK_DEPTH(4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
`ifdef ALU_SEQ_SINGLE_STEP_EN
      .step   (step),
`endif
      .bus    (bus),
      .busy   (busy),
      .halted (halted),
      .fault  (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

   function automatic logic [42:0] mk(input logic [2:0] ctl, input logic [7:0] dest);
      return {ctl, 32'd0, dest};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = mk(C_NOP, 8'd0);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic exec_to_fetch();
      cycle();
`ifdef ALU_SEQ_SINGLE_STEP_EN
      cycle();
`endif
   endtask

   task automatic wait_halted(input string name);
      int n;
      n = 0;
      while (halted !== 1'b1 && n < 20) begin
         cycle();
         n++;
      end
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s halted got %b want 1", name, halted);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      bus.zero_flag = 1'b0;
      clear_rom();
      cycle();
      cycle();
      checks++; if (bus.push !== 1'b0) begin errors++; $display("[TB] FAIL rst_push got %b want 0", bus.push); end
      checks++; if (bus.pop !== 1'b0) begin errors++; $display("[TB] FAIL rst_pop got %b want 0", bus.pop); end
      checks++; if (bus.dest_choice !== 2'b11) begin errors++; $display("[TB] FAIL rst_dc got %b want 11", bus.dest_choice); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
      checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL rst_halted got %b want 0", halted); end
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault got %b want 0", fault); end
      checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL rst_imem got %0d want 0", bus.imem_addr); end
      checks++; if (bus.instr_addr !== 6'd0) begin errors++; $display("[TB] FAIL rst_iaddr got %0d want 0", bus.instr_addr); end
      checks++; if (bus.op_code !== 8'd0 || bus.destination !== 8'd0) begin
         errors++; $display("[TB] FAIL rst_dp got op %0h dest %0h want 0 0", bus.op_code, bus.destination);
      end
      rst = 1'b1;
      cycle();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
   endtask

   task automatic test_alu_halt();
      int dc_cnt, dc_cyc, halt_cyc;
      clear_rom();
      // ALU op 01, s1c=1 s2c=2 dc=00, reserved=11, src1=5 src2=6 dest=3
      rom[0] = {C_ALU, 8'h01, 2'b01, 2'b10, 2'b00, 2'b11, 8'h05, 8'h06, 8'h03};
      rom[1] = mk(C_HALT, 8'd0);
      dc_cnt = 0; dc_cyc = -1; halt_cyc = -1;
      pulse_start();
      for (int n = 1; n <= 12; n++) begin
         if (bus.dest_choice === 2'b00) begin dc_cnt++; dc_cyc = n; end
         if (halted === 1'b1 && halt_cyc < 0) halt_cyc = n;
         if (n == 3) begin
            checks++;
            if (bus.op_code !== 8'h01 || bus.destination !== 8'h03 || bus.source1 !== 8'h05 ||
                bus.source2 !== 8'h06 || bus.source1_choice !== 2'b01 || bus.source2_choice !== 2'b10) begin
               errors++;
               $display("[TB] FAIL alu_fields got op %0h d %0h s1 %0h s2 %0h c1 %0d c2 %0d want 1 3 5 6 1 2",
                        bus.op_code, bus.destination, bus.source1, bus.source2,
                        bus.source1_choice, bus.source2_choice);
            end
         end
         cycle();
      end
      checks++; if (dc_cnt != 1) begin errors++; $display("[TB] FAIL alu_dc_count got %0d want 1", dc_cnt); end
      checks++; if (dc_cyc != 3) begin errors++; $display("[TB] FAIL alu_dc_cycle got %0d want 3", dc_cyc); end
      checks++; if (halt_cyc != HALT_CYC) begin errors++; $display("[TB] FAIL halt_cycle got %0d want %0d", halt_cyc, HALT_CYC); end
      checks++; if (bus.imem_addr !== 6'd1) begin errors++; $display("[TB] FAIL halt_pc got %0d want 1", bus.imem_addr); end
   endtask

   task automatic run_branch(input logic [2:0] ctl, input logic zf, input logic [5:0] exp, input string name);
      clear_rom();
      rom[0] = mk(C_JMP, 8'd5);
      rom[5] = mk(ctl, 8'd20);
      rom[6] = mk(C_HALT, 8'd0);
      rom[20] = mk(C_HALT, 8'd0);
      bus.zero_flag = zf;
      pulse_start();
      cycle(); cycle(); exec_to_fetch();
      checks++; if (bus.imem_addr !== 6'd5) begin errors++; $display("[TB] FAIL %s_jmp got %0d want 5", name, bus.imem_addr); end
      cycle(); cycle(); exec_to_fetch();
      checks++; if (bus.imem_addr !== exp) begin errors++; $display("[TB] FAIL %s got %0d want %0d", name, bus.imem_addr, exp); end
      wait_halted(name);
      bus.zero_flag = 1'b0;
   endtask

   task automatic test_branch();
      run_branch(C_JZ, 1'b1, 6'd20, "jz_taken");
      run_branch(C_JZ, 1'b0, 6'd6, "jz_not_taken");
      run_branch(C_JNZ, 1'b1, 6'd6, "jnz_not_taken");
      run_branch(C_JNZ, 1'b0, 6'd20, "jnz_taken");
   endtask

   task automatic test_call_ret();
      clear_rom();
      rom[2] = mk(C_CALL, 8'd40);
      rom[3] = mk(C_HALT, 8'd0);
      rom[40] = mk(C_RET, 8'd0);
      pulse_start();
      for (int k = 0; k < 2; k++) begin cycle(); cycle(); exec_to_fetch(); end
      checks++; if (bus.imem_addr !== 6'd2) begin errors++; $display("[TB] FAIL call_fetch got %0d want 2", bus.imem_addr); end
      cycle(); cycle();
      checks++; if (bus.push !== 1'b1 || bus.pop !== 1'b0) begin errors++; $display("[TB] FAIL call_push got %b%b want 10", bus.push, bus.pop); end
      checks++; if (bus.instr_addr !== 6'd3) begin errors++; $display("[TB] FAIL call_iaddr got %0d want 3", bus.instr_addr); end
      exec_to_fetch();
      checks++; if (bus.imem_addr !== 6'd40 || bus.push !== 1'b0) begin errors++; $display("[TB] FAIL call_target got %0d push %b want 40 0", bus.imem_addr, bus.push); end
      cycle(); cycle();
      checks++; if (bus.pop !== 1'b1 || bus.push !== 1'b0) begin errors++; $display("[TB] FAIL ret_pop got %b%b want 01", bus.push, bus.pop); end
      checks++; if (bus.instr_addr !== 6'd40) begin errors++; $display("[TB] FAIL ret_iaddr got %0d want 40", bus.instr_addr); end
      exec_to_fetch();
      checks++; if (bus.imem_addr !== 6'd3) begin errors++; $display("[TB] FAIL ret_target got %0d want 3", bus.imem_addr); end
      wait_halted("call_ret_halt");
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL call_ret_fault got %b want 0", fault); end
   endtask

   task automatic test_stack_fault();
      int push_cnt;
      clear_rom();
      for (int k = 0; k < 5; k++) rom[k*10] = mk(C_CALL, 8'((k+1)*10));
      rom[50] = mk(C_HALT, 8'd0);
      push_cnt = 0;
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         checks++; if (bus.imem_addr !== 6'(k*10)) begin errors++; $display("[TB] FAIL nest_fetch%0d got %0d want %0d", k, bus.imem_addr, k*10); end
         cycle(); cycle();
         if (bus.push === 1'b1) push_cnt++;
         if (k < 4) exec_to_fetch(); else cycle();
      end
      checks++; if (push_cnt != 4) begin errors++; $display("[TB] FAIL overflow_pushes got %0d want 4", push_cnt); end
      checks++; if (halted !== 1'b1 || fault !== 1'b1) begin errors++; $display("[TB] FAIL overflow got halted %b fault %b want 1 1", halted, fault); end
      clear_rom();
      rom[0] = mk(C_RET, 8'd0);
      pulse_start();
      checks++; if (fault !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL restart got fault %b busy %b want 0 1", fault, busy); end
      cycle(); cycle();
      checks++; if (bus.pop !== 1'b0) begin errors++; $display("[TB] FAIL underflow_pop got %b want 0", bus.pop); end
      cycle();
      checks++; if (halted !== 1'b1 || fault !== 1'b1) begin errors++; $display("[TB] FAIL underflow got halted %b fault %b want 1 1", halted, fault); end
   endtask

   task automatic test_pc_wrap();
      clear_rom();
      pulse_start();
      repeat (63) begin cycle(); cycle(); exec_to_fetch(); end
      checks++; if (bus.imem_addr !== 6'd63) begin errors++; $display("[TB] FAIL wrap_63 got %0d want 63", bus.imem_addr); end
      cycle(); cycle(); exec_to_fetch();
      checks++; if (bus.imem_addr !== 6'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL wrap_0 got %0d busy %b want 0 1", bus.imem_addr, busy); end
   endtask

   task automatic test_reset_mid_call();
      rst = 1'b0;
      cycle();
      rst = 1'b1;
      cycle();
      clear_rom();
      rom[0] = mk(C_CALL, 8'd40);
      pulse_start();
      cycle(); cycle();
      checks++; if (bus.push !== 1'b1) begin errors++; $display("[TB] FAIL mid_call_push got %b want 1", bus.push); end
      #2 rst = 1'b0;
      #1;
      checks++; if (bus.push !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("[TB] FAIL async_rst got push %b busy %b halted %b want 0 0 0", bus.push, busy, halted);
      end
      checks++; if (bus.dest_choice !== 2'b11 || bus.imem_addr !== 6'd0 || bus.instr_addr !== 6'd0) begin
         errors++; $display("[TB] FAIL async_rst_out got dc %b imem %0d iaddr %0d want 11 0 0", bus.dest_choice, bus.imem_addr, bus.instr_addr);
      end
      cycle();
      rst = 1'b1;
      cycle();
      rom[0] = mk(C_RET, 8'd0);
      pulse_start();
      checks++; if (bus.imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL resume_pc got %0d want 0", bus.imem_addr); end
      cycle(); cycle();
      checks++; if (bus.pop !== 1'b0) begin errors++; $display("[TB] FAIL rst_stack_pop got %b want 0", bus.pop); end
      cycle();
      checks++; if (fault !== 1'b1 || halted !== 1'b1) begin errors++; $display("[TB] FAIL rst_stack_empty got fault %b halted %b want 1 1", fault, halted); end
   endtask

`ifdef ALU_SEQ_SINGLE_STEP_EN
   task automatic test_single_step();
      int dc_cnt;
      for (int i = 0; i < 64; i++) rom[i] = {C_ALU, 40'd0};
      step = 1'b0;
      dc_cnt = 0;
      pulse_start();
      cycle(); cycle();
      checks++; if (bus.dest_choice !== 2'b00) begin errors++; $display("[TB] FAIL step_exec got %b want 00", bus.dest_choice); end
      repeat (5) begin
         cycle();
         if (bus.dest_choice === 2'b00) dc_cnt++;
      end
      checks++; if (dc_cnt != 0 || busy !== 1'b1 || bus.imem_addr !== 6'd1) begin
         errors++; $display("[TB] FAIL stepwait got writes %0d busy %b pc %0d want 0 1 1", dc_cnt, busy, bus.imem_addr);
      end
      step = 1'b1;
      cycle();
      step = 1'b0;
      cycle(); cycle();
      checks++; if (bus.dest_choice !== 2'b00) begin errors++; $display("[TB] FAIL step_resume got %b want 00", bus.dest_choice); end
      step = 1'b1;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
`ifdef ALU_SEQ_SINGLE_STEP_EN
      step = 1'b1;
`endif
      test_reset();
      test_alu_halt();
      test_branch();
      test_call_ret();
      test_stack_fault();
      test_pc_wrap();
      test_reset_mid_call();
`ifdef ALU_SEQ_SINGLE_STEP_EN
      test_single_step();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout got running want finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
